sysid_check_ctrl: RTL
=====================

SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0012_3456: required system ID word at slave address 0.
REQ-002 Parameter EXPECTED_TS, default 32'h5D82_94FE: required timestamp word at slave address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum waitrequest-high cycles per read before abort; range 1..65535.
REQ-004 Parameter MAX_RETRIES, default 3: extra attempts after a mismatch; used only with the macro in REQ-026.
REQ-005 clock  in  1  sole clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request one check sequence; sampled only in IDLE.
REQ-008 busy  out  1  high while a sequence is in progress.
REQ-009 done  out  1  one-cycle pulse at sequence end.
REQ-010 id_ok / ts_ok  out  1 each  compare results of the last completed sequence.
REQ-011 timeout  out  1  last sequence aborted on read timeout.
REQ-012 rd_id / rd_ts  out  32 each  last captured ID and timestamp words.
REQ-013 avm_address  out  1  Avalon-MM master word address (0 = ID, 1 = timestamp).
REQ-014 avm_read  out  1  Avalon-MM read strobe.
REQ-015 avm_waitrequest  in  1  slave stall.
REQ-016 avm_readdata  in  32  slave read data; zero read latency, valid when avm_read high and avm_waitrequest low.

Function
REQ-017 FSM states: IDLE, RD_ID, GAP, RD_TS, CMP, DONE.
- IDLE -> RD_ID when start is high.
- RD_ID -> GAP on accept.
- GAP -> RD_TS unconditionally.
- RD_TS -> CMP on accept.
- CMP -> DONE.
- DONE -> IDLE.
REQ-018 Accept: avm_read high and avm_waitrequest low. avm_readdata is captured into rd_id or rd_ts in that cycle.
REQ-019 avm_read is high exactly in RD_ID and RD_TS. avm_address is 0 in RD_ID and 1 in RD_TS, and is held stable while stalled.
REQ-020 Zero-wait timing, start sampled at edge k:
- read addr 0 at k+1.
- gap at k+2.
- read addr 1 at k+3.
- compare at k+4.
- done=1 and busy=0 at k+5.
- busy high k+1..k+4.
REQ-021 Leaving IDLE clears id_ok, ts_ok and timeout. rd_id and rd_ts hold until overwritten.
REQ-022 In CMP: id_ok <= (rd_id == EXPECTED_ID) and ts_ok <= (rd_ts == EXPECTED_TS). Comparisons are full 32-bit; no masking.
REQ-023 A wait counter clears on entry to each read state and increments per stalled cycle. When it equals TIMEOUT_CYCLES:
- drop avm_read next cycle.
- set timeout=1, id_ok=0, ts_ok=0.
- go to DONE and skip CMP.
REQ-024 start is ignored in every state except IDLE, including DONE. A start held high in IDLE launches back-to-back sequences, one per IDLE visit.

Reset
REQ-025 When reset is high at a clock edge, at that edge:
- state = IDLE.
- busy, done, id_ok, ts_ok, timeout, avm_read, avm_address = 0.
- rd_id, rd_ts, wait counter, retry counter = 0.
- mid-sequence reset drops avm_read at that edge with no completion pulse.

Configuration
REQ-026 Macro SYSID_CHECK_RETRY_EN defined:
- CMP with either compare false and retry count < MAX_RETRIES: increment the retry count and go to RD_ID instead of DONE; done is not pulsed.
- The retry count clears on leaving IDLE.
- Timeouts are never retried.
REQ-027 Macro not defined: single attempt; MAX_RETRIES has no effect; no retry counter logic is synthesized.

Structure
REQ-028 Package sysid_check_pkg holds the FSM state enum, default EXPECTED_ID/EXPECTED_TS constants, and the slave address constants ADDR_ID=0 and ADDR_TS=1.
REQ-029 Sub-module sysid_check_timeout holds the wait counter, with inputs clear/enable and output expired. The rest of the design is flat.

Verification
REQ-030 Zero-wait slave returns 32'h0012_3456 and 32'h5D82_94FE; pulse start -> done at k+5, id_ok=1, ts_ok=1, timeout=0, one read per address.
REQ-031 waitrequest held high 3 cycles on the ID read -> avm_read and avm_address stable throughout; done at k+8; results as in REQ-030.
REQ-032 waitrequest stuck high, TIMEOUT_CYCLES=4 -> after 4 stalled cycles avm_read drops, timeout=1, id_ok=0, done pulses once, no timestamp read.
REQ-033 Slave returns timestamp 32'h0 ->
- macro off: id_ok=1, ts_ok=0 after one attempt.
- macro on, MAX_RETRIES=3: 4 attempts (8 reads), then done with ts_ok=0.
REQ-034 reset asserted during RD_TS -> next cycle avm_read=0, busy=0, all status 0, no done; a new start then completes normally.
REQ-035 start held high continuously -> new sequence begins the cycle after each done; start pulses during busy are ignored.

Source files
------------

// File: rtl/sysid_check_pkg.sv
// -----------------------------------------------------------------------------
// sysid_check_pkg
// Shared definitions for the system-ID check controller:
//   state_t              FSM state encoding (also exported on the debug port)
//   DEFAULT_EXPECTED_ID  default required ID word (slave address 0)
//   DEFAULT_EXPECTED_TS  default required timestamp word (slave address 1)
//   ADDR_ID / ADDR_TS    Avalon-MM word addresses of the two registers
//   WAIT_W               width of the read wait counter
// -----------------------------------------------------------------------------
package sysid_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_GAP   = 3'd2,
    ST_RD_TS = 3'd3,
    ST_CMP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0012_3456;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h5D82_94FE;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Wide enough for the largest allowed timeout (65535).
  localparam int WAIT_W = 16;

  function automatic logic is_read_state(input state_t s);
    return (s == ST_RD_ID) || (s == ST_RD_TS);
  endfunction

endpackage

// File: rtl/sysid_check_timeout.sv
// -----------------------------------------------------------------------------
// sysid_check_timeout
// Wait counter for one Avalon-MM read. Counts stalled cycles and flags the
// stalled cycle that brings the count to TIMEOUT_CYCLES.
// Ports:
//   clock    in   sole clock, rising edge
//   reset    in   synchronous active-high reset (count -> 0)
//   clear    in   restart the count (outside a read, or on accept)
//   enable   in   this cycle is a stalled read cycle
//   expired  out  this stalled cycle is the TIMEOUT_CYCLES-th one; the
//                 controller aborts the read at the end of it
// -----------------------------------------------------------------------------
module sysid_check_timeout
  import sysid_check_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST_COUNT = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // The count becomes TIMEOUT_CYCLES on the same edge the controller leaves
  // the read state, so avm_read is low in the following cycle.
  assign expired = enable && (count == LAST_COUNT);

endmodule

// File: rtl/sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// sysid_check_ctrl
// Reads the system ID (address 0) and build timestamp (address 1) from an
// Avalon-MM slave, compares both against expected constants and reports the
// result. Optional feature macro: SYSID_CHECK_RETRY_EN (re-run the reads after
// a compare mismatch, up to MAX_RETRIES extra attempts).
//
// Handshake: a read is accepted in any cycle where avm_read is high and
// avm_waitrequest is low; avm_readdata is captured in that same cycle (zero
// read latency). While waitrequest is high, avm_read and avm_address hold.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   start               request a check sequence (only sampled in IDLE)
//   busy                sequence in progress (RD_ID, GAP, RD_TS, CMP)
//   done                one-cycle pulse at sequence end (DONE state)
//   id_ok, ts_ok        compare results of the last completed sequence
//   timeout             last sequence aborted on a read timeout
//   rd_id, rd_ts        last captured ID / timestamp words
//   avm_address         word address (0 = ID, 1 = timestamp)
//   avm_read            read strobe
//   avm_waitrequest     slave stall
//   avm_readdata        slave read data
//   dbg_state           current FSM state
// -----------------------------------------------------------------------------
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] rd_id,
  output logic [31:0] rd_ts,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [2:0]  dbg_state
);

  state_t state;
  state_t state_next;

  logic in_read;
  logic accept;
  logic expired;
  logic retry_now;

  assign in_read   = is_read_state(state);
  assign accept    = avm_read && !avm_waitrequest;
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Read wait counter: held at zero outside the read states and restarted on
  // each accept, so every read starts from a fresh count.
  // ---------------------------------------------------------------------------
  sysid_check_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_read || accept),
    .enable  (in_read && avm_waitrequest),
    .expired (expired)
  );

  // ---------------------------------------------------------------------------
  // Retry support
  // ---------------------------------------------------------------------------
`ifdef SYSID_CHECK_RETRY_EN
  localparam int RETRY_W = 8;

  logic [RETRY_W-1:0] retry_cnt;
  logic               mismatch;

  assign mismatch  = (rd_id != EXPECTED_ID) || (rd_ts != EXPECTED_TS);
  assign retry_now = (state == ST_CMP) && mismatch &&
                     (retry_cnt < RETRY_W'(MAX_RETRIES));

  always_ff @(posedge clock) begin
    if (reset) begin
      retry_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      retry_cnt <= '0;
    end else if (retry_now) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  assign retry_now = 1'b0;

  // MAX_RETRIES only affects the retry build; this empty guard keeps the
  // parameter referenced in the single-attempt build.
  if (MAX_RETRIES < 0) begin : g_max_retries_unused
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    done        = 1'b0;
    avm_read    = 1'b0;
    avm_address = ADDR_ID;

    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RD_ID;
      end
      ST_RD_ID: begin
        busy     = 1'b1;
        avm_read = 1'b1;
        if (expired) begin
          state_next = ST_DONE;
        end else if (accept) begin
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        busy       = 1'b1;
        state_next = ST_RD_TS;
      end
      ST_RD_TS: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = ADDR_TS;
        if (expired) begin
          state_next = ST_DONE;
        end else if (accept) begin
          state_next = ST_CMP;
        end
      end
      ST_CMP: begin
        busy       = 1'b1;
        state_next = retry_now ? ST_RD_ID : ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_id   <= '0;
      rd_ts   <= '0;
      id_ok   <= 1'b0;
      ts_ok   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b0;
      end

      if (accept && state == ST_RD_ID) rd_id <= avm_readdata;
      if (accept && state == ST_RD_TS) rd_ts <= avm_readdata;

      if (state == ST_CMP) begin
        id_ok <= (rd_id == EXPECTED_ID);
        ts_ok <= (rd_ts == EXPECTED_TS);
      end

      // expired only fires on a stalled cycle, so it never coincides with
      // an accept or with CMP.
      if (expired) begin
        timeout <= 1'b1;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
      end
    end
  end

endmodule
